// File: rtl/ay_psg.sv
// AY-3-8910 compatible sound generator on the ZX128 ports FFFD/BFFD.
// Three tone channels, LFSR noise, envelope, log volume table, 10-bit mix and PWM output.
module ay_psg #(
   parameter int CLK_DIV = 14
) (
   input  logic        clock_25,
   input  logic        RESET_N,
   input  logic [15:0] A,
   input  logic [7:0]  D_in,
   input  logic        nIORQ,
   input  logic        nRD,
   input  logic        nWR,
   output logic [7:0]  D_out,
   output logic        d_oe,
   output logic [9:0]  audio,
   output logic        audio_pwm
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [7:0]       r_regs [16];
   logic [3:0]       r_sel;
   logic [1:0]       r_iorqSync, r_wrSync, r_rdSync;
   logic             r_writePrev;
   logic [DIV_W-1:0] r_div;
   logic [3:0]       r_ceCnt;
   logic             r_noiseHalf;
   logic [4:0]       r_noiseCnt;
   logic [16:0]      r_lfsr;
   logic [15:0]      r_envCnt;
   logic [3:0]       r_envStep;
   logic             r_envAtt, r_envHeld, r_envHoldHigh;
   logic [9:0]       r_audio, r_pc;
   logic             r_pwm;

   logic        w_write, w_writeEdge, w_selWrite, w_dataWrite, w_unusedAddr;
   logic        w_ce, w_tick8, w_tick16, w_noiseTick, w_noise;
   logic [5:0]  w_noiseNext;
   logic        w_noiseExpire;
   logic [16:0] w_envNext;
   logic [15:0] w_envPeriod;
   logic        w_envExpire;
   logic [3:0]  w_envLevel;
   logic [2:0]  w_tone, w_gate;
   logic [7:0]  w_amp [3];
   logic [9:0]  w_mix;

   function automatic logic [7:0] regMask(input logic [3:0] idx);
      case (idx)
         4'd1, 4'd3, 4'd5, 4'd13: regMask = 8'h0F;
         4'd6, 4'd8, 4'd9, 4'd10: regMask = 8'h1F;
         default:                 regMask = 8'hFF;
      endcase
   endfunction

   function automatic logic [7:0] volTable(input logic [3:0] lvl);
      case (lvl)
         4'd0: volTable = 8'd0;    4'd1: volTable = 8'd1;
         4'd2: volTable = 8'd2;    4'd3: volTable = 8'd3;
         4'd4: volTable = 8'd4;    4'd5: volTable = 8'd6;
         4'd6: volTable = 8'd8;    4'd7: volTable = 8'd11;
         4'd8: volTable = 8'd16;   4'd9: volTable = 8'd23;
         4'd10: volTable = 8'd32;  4'd11: volTable = 8'd45;
         4'd12: volTable = 8'd64;  4'd13: volTable = 8'd90;
         4'd14: volTable = 8'd128; default: volTable = 8'd255;
      endcase
   endfunction

   // Strobes are asynchronous to clock_25; a write acts once, on its first synchronised cycle.
   assign w_write      = ~r_iorqSync[1] & ~r_wrSync[1] & r_rdSync[1];
   assign w_writeEdge  = w_write & ~r_writePrev;
   assign w_selWrite   = w_writeEdge & A[15] & A[14] & ~A[1] & (D_in[7:4] == 4'd0);
   assign w_dataWrite  = w_writeEdge & A[15] & ~A[14] & ~A[1];
   assign w_unusedAddr = ^{A[13:2], A[0]};

   assign d_oe  = RESET_N & ~nIORQ & ~nRD & A[15] & A[14] & ~A[1];
   assign D_out = d_oe ? r_regs[r_sel] : 8'hFF;

   always_ff @(posedge clock_25) begin
      if (!RESET_N) begin
         r_iorqSync  <= 2'b11;
         r_wrSync    <= 2'b11;
         r_rdSync    <= 2'b11;
         r_writePrev <= 1'b0;
         r_sel       <= 4'd0;
         r_regs      <= '{default: 8'h00};
      end else begin
         r_iorqSync  <= {r_iorqSync[0], nIORQ};
         r_wrSync    <= {r_wrSync[0], nWR};
         r_rdSync    <= {r_rdSync[0], nRD};
         r_writePrev <= w_write;
         if (w_selWrite)  r_sel <= D_in[3:0];
         if (w_dataWrite) r_regs[r_sel] <= D_in & regMask(r_sel);
      end
   end

   assign w_ce        = (r_div == DIV_LAST);
   assign w_tick8     = w_ce & (r_ceCnt[2:0] == 3'd7);
   assign w_tick16    = w_ce & (r_ceCnt == 4'd15);
   assign w_noiseTick = w_tick8 & r_noiseHalf;

   always_ff @(posedge clock_25) begin
      if (!RESET_N) begin
         r_div       <= '0;
         r_ceCnt     <= 4'd0;
         r_noiseHalf <= 1'b0;
      end else begin
         r_div <= w_ce ? '0 : r_div + DIV_W'(1);
         if (w_ce)    r_ceCnt     <= r_ceCnt + 4'd1;
         if (w_tick8) r_noiseHalf <= ~r_noiseHalf;
      end
   end

   // Period 0 behaves as 1; a period lowered below the count expires on the next tick.
   for (genvar ch = 0; ch < 3; ch++) begin : g_chan
      logic [11:0] r_cnt;
      logic        r_out;
      logic [11:0] w_period;
      logic [12:0] w_next;
      logic        w_expire;
      logic [3:0]  w_level;

      assign w_period = {r_regs[2*ch+1][3:0], r_regs[2*ch]};
      assign w_next   = {1'b0, r_cnt} + 13'd1;
      assign w_expire = w_next >= {1'b0, (w_period == 12'd0) ? 12'd1 : w_period};

      always_ff @(posedge clock_25) begin
         if (!RESET_N) begin
            r_cnt <= 12'd0;
            r_out <= 1'b0;
         end else if (w_tick8) begin
            if (w_expire) begin
               r_cnt <= 12'd0;
               r_out <= ~r_out;
            end else begin
               r_cnt <= w_next[11:0];
            end
         end
      end

      assign w_level   = r_regs[8+ch][4] ? w_envLevel : r_regs[8+ch][3:0];
      assign w_amp[ch] = w_gate[ch] ? volTable(w_level) : 8'd0;
      assign w_tone[ch] = r_out;
   end

   assign w_noise       = r_lfsr[0];
   assign w_noiseNext   = {1'b0, r_noiseCnt} + 6'd1;
   assign w_noiseExpire = w_noiseNext >= {1'b0, (r_regs[6][4:0] == 5'd0) ? 5'd1 : r_regs[6][4:0]};

   always_ff @(posedge clock_25) begin
      if (!RESET_N) begin
         r_noiseCnt <= 5'd0;
         r_lfsr     <= 17'h1;
      end else if (w_noiseTick) begin
         if (w_noiseExpire) begin
            r_noiseCnt <= 5'd0;
            r_lfsr     <= {r_lfsr[0] ^ r_lfsr[3], r_lfsr[16:1]};
         end else begin
            r_noiseCnt <= w_noiseNext[4:0];
         end
      end
   end

   assign w_envPeriod = {r_regs[12], r_regs[11]};
   assign w_envNext   = {1'b0, r_envCnt} + 17'd1;
   assign w_envExpire = w_envNext >= {1'b0, (w_envPeriod == 16'd0) ? 16'd1 : w_envPeriod};
   assign w_envLevel  = r_envHeld ? {4{r_envHoldHigh}} : (r_envAtt ? r_envStep : ~r_envStep);

   // R13 bits: [3] continue, [2] attack, [1] alternate, [0] hold. A write to R13 restarts the shape.
   always_ff @(posedge clock_25) begin
      if (!RESET_N) begin
         r_envCnt      <= 16'd0;
         r_envStep     <= 4'd0;
         r_envAtt      <= 1'b0;
         r_envHeld     <= 1'b0;
         r_envHoldHigh <= 1'b0;
      end else if (w_dataWrite && r_sel == 4'd13) begin
         r_envCnt  <= 16'd0;
         r_envStep <= 4'd0;
         r_envHeld <= 1'b0;
         r_envAtt  <= D_in[2];
      end else if (w_tick16) begin
         if (!w_envExpire) begin
            r_envCnt <= w_envNext[15:0];
         end else begin
            r_envCnt <= 16'd0;
            if (!r_envHeld) begin
               if (r_envStep != 4'd15) begin
                  r_envStep <= r_envStep + 4'd1;
               end else if (!r_regs[13][3]) begin
                  r_envHeld     <= 1'b1;
                  r_envHoldHigh <= 1'b0;
               end else if (r_regs[13][0]) begin
                  r_envHeld     <= 1'b1;
                  r_envHoldHigh <= r_regs[13][2] ^ r_regs[13][1];
               end else begin
                  r_envStep <= 4'd0;
                  if (r_regs[13][1]) r_envAtt <= ~r_envAtt;
               end
            end
         end
      end
   end

   assign w_gate = (w_tone | r_regs[7][2:0]) & ({3{w_noise}} | r_regs[7][5:3]);
   assign w_mix  = {2'b00, w_amp[0]} + {2'b00, w_amp[1]} + {2'b00, w_amp[2]};

   always_ff @(posedge clock_25) begin
      if (!RESET_N) begin
         r_audio <= 10'd0;
         r_pc    <= 10'd0;
         r_pwm   <= 1'b0;
      end else begin
         r_audio <= w_mix;
         r_pc    <= r_pc + 10'd1;
         r_pwm   <= (r_pc < r_audio);
      end
   end

   assign audio     = r_audio;
   assign audio_pwm = r_pwm;

endmodule
